// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared constants, width helper and pointer type for fifo_sync_prog
// Revision : 1.0
// ============================================================================
package fifo_pkg;

   localparam int FWFT_STD      = 0;
   localparam int FWFT_FALLTHRU = 1;

   localparam int DEFAULT_DEPTH = 256;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

   localparam int DEFAULT_ADDR_WIDTH = addr_width(DEFAULT_DEPTH);

   // Pointer for the default geometry; the extra MSB is the wrap bit
   typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sync_prog_chk.sv
`default_nettype none
// ============================================================================
// fifo_sync_prog_chk : assertion interface for status, pointer and sticky-flag rules
// Revision : 1.0
// ============================================================================
interface fifo_sync_prog_chk
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input logic                clk,
   input logic                rstn,
   input logic                wr_en,
   input logic                rd_en,
   input logic                clear_err,
   input logic                full,
   input logic                empty,
   input logic                overflow,
   input logic                underflow,
   input logic [ADDR_WIDTH:0] count,
   input logic [ADDR_WIDTH:0] wr_ptr,
   input logic [ADDR_WIDTH:0] rd_ptr
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   a_full: assert property (@(posedge clk) disable iff (!rstn) full == (count == DEPTH_C))
      else $error("FAIL chk_full: full=%0b count=%0d", full, count);
   a_empty: assert property (@(posedge clk) disable iff (!rstn) empty == (count == '0))
      else $error("FAIL chk_empty: empty=%0b count=%0d", empty, count);

   a_no_wr: assert property (@(posedge clk) disable iff (!rstn)
      (wr_en && full) |=> (wr_ptr == $past(wr_ptr)))
      else $error("FAIL chk_no_wr: wr_ptr=%0d moved on rejected write", wr_ptr);
   a_no_rd: assert property (@(posedge clk) disable iff (!rstn)
      (rd_en && empty) |=> (rd_ptr == $past(rd_ptr)))
      else $error("FAIL chk_no_rd: rd_ptr=%0d moved on rejected read", rd_ptr);

   a_ovf_set: assert property (@(posedge clk) disable iff (!rstn)
      (wr_en && full) |=> overflow)
      else $error("FAIL chk_ovf_set: overflow=%0b required 1", overflow);
   a_ovf_hold: assert property (@(posedge clk) disable iff (!rstn)
      (overflow && !clear_err) |=> overflow)
      else $error("FAIL chk_ovf_hold: overflow=%0b required 1", overflow);
   a_unf_set: assert property (@(posedge clk) disable iff (!rstn)
      (rd_en && empty) |=> underflow)
      else $error("FAIL chk_unf_set: underflow=%0b required 1", underflow);
   a_unf_hold: assert property (@(posedge clk) disable iff (!rstn)
      (underflow && !clear_err) |=> underflow)
      else $error("FAIL chk_unf_hold: underflow=%0b required 1", underflow);

endinterface
`default_nettype wire

// File: rtl/fifo_sync_prog_if.sv
`default_nettype none
// ============================================================================
// fifo_sync_prog_if : producer/consumer bus of the synchronous FIFO
// Revision : 1.0
// ============================================================================
interface fifo_sync_prog_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   af_th;
   logic [ADDR_WIDTH:0]   ae_th;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  clear_err;

   modport master (
      output wr_en, data_in, rd_en, af_th, ae_th, clear_err,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, af_th, ae_th, clear_err,
      output data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// fifo_mem : dual-port storage array, synchronous write, asynchronous read
// Revision : 1.0
// ============================================================================
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// fifo_sync_prog : single-clock FIFO with STD/FWFT read, fill count, programmable
//                  almost-full/almost-empty thresholds and sticky error flags
// Revision : 1.0
// ============================================================================
module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = addr_width(DEPTH),
   parameter int FWFT       = FWFT_STD
) (
   input  logic            clk,
   input  logic            rstn,
   fifo_sync_prog_if.slave bus
);
   typedef logic [ADDR_WIDTH:0] cnt_t;
   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   cnt_t                  wr_ptr_q, wr_ptr_d;
   cnt_t                  rd_ptr_q, rd_ptr_d;
   cnt_t                  count;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic                  full, empty;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Modular difference of the wrap-bit pointers gives 0..DEPTH without ambiguity
   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   always_comb begin
      wr_acc      = bus.wr_en && !full;
      rd_acc      = bus.rd_en && !empty;
      wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
      overflow_d  = (bus.wr_en && full) || (overflow_q && !bus.clear_err);
      underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.clear_err);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (bus.data_in),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (mem_rdata)
   );

   generate
      if (FWFT == FWFT_FALLTHRU) begin : g_fwft
         assign bus.data_out = mem_rdata;
         assign bus.rd_valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] data_q, data_d;
         logic                  rd_valid_q, rd_valid_d;

         always_comb begin
            data_d     = rd_acc ? mem_rdata : data_q;
            rd_valid_d = rd_acc;
         end

         always_ff @(posedge clk) begin
            if (!rstn) begin
               data_q     <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               data_q     <= data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign bus.data_out = data_q;
         assign bus.rd_valid = rd_valid_q;
      end
   endgenerate

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.count        = count;
   assign bus.almost_full  = (bus.af_th != '0) && (count >= bus.af_th);
   assign bus.almost_empty = (count <= bus.ae_th);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   fifo_sync_prog_chk #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_chk (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en     (bus.wr_en),
      .rd_en     (bus.rd_en),
      .clear_err (bus.clear_err),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow_q),
      .underflow (underflow_q),
      .count     (count),
      .wr_ptr    (wr_ptr_q),
      .rd_ptr    (rd_ptr_q)
   );

endmodule
`default_nettype wire
